// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencing controller.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // LO value written when a divide has a zero divisor.
    localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_RUN  = 2'd2,
        DIV_ZERO = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the EX-stage multiplier and divider.
// Holds the pipeline while a HI/LO arithmetic op is in flight and
// emits one HI/LO write pulse when its result exists.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        mul_signed_o,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    input  logic [63:0] mul_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_a_o,
    output logic [31:0] div_b_o,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        stallreq,
    output logic        busy,
    output logic [1:0]  hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [2:0]         op_q;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic               latch;
    logic               accept;

    // State, latency counter and operand latches; latched only when an op is taken.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (latch) begin
                op_q <= op;
                a_q  <= src_a;
                b_q  <= src_b;
            end
        end
    end

    // Next-state and output decode; flush beats completion, reset silences everything.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        latch        = 1'b0;
        accept       = op_valid & ~flush;
        mul_signed_o = 1'b0;
        mul_a_o      = '0;
        mul_b_o      = '0;
        div_start_o  = 1'b0;
        div_annul_o  = 1'b0;
        div_signed_o = 1'b0;
        div_a_o      = '0;
        div_b_o      = '0;
        stallreq     = 1'b0;
        busy         = 1'b0;
        hilo_we      = 2'b00;
        hi_o         = '0;
        lo_o         = '0;

        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            latch      = 1'b1;
                            stallreq   = 1'b1;
                            cnt_next   = CNT_W'(MUL_LAT - 1);
                            state_next = MUL_WAIT;
                        end
                        OP_DIV, OP_DIVU: begin
                            latch      = 1'b1;
                            stallreq   = 1'b1;
                            state_next = (src_b == 32'd0) ? DIV_ZERO : DIV_RUN;
                        end
                        OP_MTHI: begin
                            hilo_we = 2'b10;
                            hi_o    = src_a;
                        end
                        OP_MTLO: begin
                            hilo_we = 2'b01;
                            lo_o    = src_a;
                        end
                        default: ;
                    endcase
                end
            end

            MUL_WAIT: begin
                busy         = 1'b1;
                mul_a_o      = a_q;
                mul_b_o      = b_q;
                mul_signed_o = (op_q == OP_MULT);
                if (flush) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    hilo_we    = 2'b11;
                    hi_o       = mul_result_i[63:32];
                    lo_o       = mul_result_i[31:0];
                    state_next = IDLE;
                end else begin
                    stallreq = 1'b1;
                    cnt_next = cnt - CNT_W'(1);
                end
            end

            DIV_RUN: begin
                busy         = 1'b1;
                div_a_o      = a_q;
                div_b_o      = b_q;
                div_signed_o = (op_q == OP_DIV);
                if (flush) begin
                    div_annul_o = 1'b1;
                    state_next  = IDLE;
                end else if (div_ready_i) begin
                    hilo_we    = 2'b11;
                    hi_o       = div_result_i[63:32];
                    lo_o       = div_result_i[31:0];
                    state_next = IDLE;
                end else begin
                    div_start_o = 1'b1;
                    stallreq    = 1'b1;
                end
            end

            DIV_ZERO: begin
                busy       = 1'b1;
                state_next = IDLE;
                if (!flush) begin
                    hilo_we = 2'b11;
                    hi_o    = a_q;
                    lo_o    = DIV_ZERO_LO;
                end
            end

            default: state_next = IDLE;
        endcase

        if (!resetn) begin
            mul_signed_o = 1'b0;
            mul_a_o      = '0;
            mul_b_o      = '0;
            div_start_o  = 1'b0;
            div_annul_o  = 1'b0;
            div_signed_o = 1'b0;
            div_a_o      = '0;
            div_b_o      = '0;
            stallreq     = 1'b0;
            busy         = 1'b0;
            hilo_we      = 2'b00;
            hi_o         = '0;
            lo_o         = '0;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl with simple multiplier/divider environment models.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int MUL_LAT = 2;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        mul_signed_o;
    logic [31:0] mul_a_o;
    logic [31:0] mul_b_o;
    logic [63:0] mul_result_i;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_a_o;
    logic [31:0] div_b_o;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        stallreq;
    logic        busy;
    logic [1:0]  hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total = 0;
    int bad   = 0;

    muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .op_valid     (op_valid),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .mul_signed_o (mul_signed_o),
        .mul_a_o      (mul_a_o),
        .mul_b_o      (mul_b_o),
        .mul_result_i (mul_result_i),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_a_o      (div_a_o),
        .div_b_o      (div_b_o),
        .div_ready_i  (div_ready_i),
        .div_result_i (div_result_i),
        .stallreq     (stallreq),
        .busy         (busy),
        .hilo_we      (hilo_we),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: one register stage, so a product is visible two cycles after the op is accepted.
    always @(posedge clk) begin
        if (mul_signed_o)
            mul_result_i <= 64'(longint'($signed(mul_a_o)) * longint'($signed(mul_b_o)));
        else
            mul_result_i <= {32'd0, mul_a_o} * {32'd0, mul_b_o};
    end

    // Divider model result path; the bench itself decides when ready rises.
    always_comb begin
        div_result_i = 64'd0;
        if (div_b_o != 32'd0) begin
            if (div_signed_o)
                div_result_i = {32'($signed(div_a_o) % $signed(div_b_o)),
                                32'($signed(div_a_o) / $signed(div_b_o))};
            else
                div_result_i = {div_a_o % div_b_o, div_a_o / div_b_o};
        end
    end

    // Abort if anything stalls far beyond any legal op length.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected architectural outcome of one op: kind 0 mul, 1 div, 2 div-by-zero, 3 move, 4 ignored.
    function automatic void referenceModel(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                           output int kind, output logic [1:0] we,
                                           output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        int sa;
        int sb;
        sa = int'(a);
        sb = int'(b);
        kind = 4;
        we = 2'b00;
        hi = 32'd0;
        lo = 32'd0;
        case (o)
            OP_MULT: begin
                p = 64'(longint'(sa) * longint'(sb));
                kind = 0; we = 2'b11; hi = p[63:32]; lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                kind = 0; we = 2'b11; hi = p[63:32]; lo = p[31:0];
            end
            OP_DIV, OP_DIVU: begin
                we = 2'b11;
                if (b == 32'd0) begin
                    kind = 2; hi = a; lo = 32'hFFFF_FFFF;
                end else if (o == OP_DIV) begin
                    kind = 1; hi = 32'(sa % sb); lo = 32'(sa / sb);
                end else begin
                    kind = 1; hi = a % b; lo = a / b;
                end
            end
            OP_MTHI: begin kind = 3; we = 2'b10; hi = a; end
            OP_MTLO: begin kind = 3; we = 2'b01; lo = a; end
            default: ;
        endcase
    endfunction

    // Present one op starting at the next edge and follow it to completion or flush.
    // dlat = cycles the divider needs with start high; flush_cyc = cycle (0 = accept) to flush, -1 = never.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input int dlat, input int flush_cyc);
        int kind;
        int k;
        int starts;
        logic [1:0]  ewe;
        logic [31:0] ehi;
        logic [31:0] elo;
        referenceModel(o, a, b, kind, ewe, ehi, elo);
        k = (kind == 0) ? MUL_LAT : (kind == 1) ? dlat + 1 : (kind == 2) ? 1 : 0;
        starts = 0;

        @(posedge clk); #1;
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        flush = (flush_cyc == 0); div_ready_i = 1'b0;
        #1;
        checkOutput("accept_busy", 64'(busy), 64'(0));
        if (flush_cyc == 0) begin
            checkOutput("flush_idle_stall", 64'(stallreq), 64'(0));
            checkOutput("flush_idle_we", 64'(hilo_we), 64'(0));
            return;
        end
        checkOutput("accept_stall", 64'(stallreq), 64'(kind <= 2));
        checkOutput("idle_mul_a", 64'(mul_a_o), 64'(0));
        if (kind == 3) begin
            checkOutput("mt_we", 64'(hilo_we), 64'(ewe));
            checkOutput("mt_hi", 64'(hi_o), 64'(ehi));
            checkOutput("mt_lo", 64'(lo_o), 64'(elo));
        end else begin
            checkOutput("accept_we", 64'(hilo_we), 64'(0));
        end

        for (int c = 1; c <= k; c++) begin
            @(posedge clk); #1;
            flush = (c == flush_cyc);
            div_ready_i = (kind == 1) && (c == k);
            #1;
            checkOutput("run_busy", 64'(busy), 64'(1));
            if (flush) begin
                checkOutput("flush_stall", 64'(stallreq), 64'(0));
                checkOutput("flush_we", 64'(hilo_we), 64'(0));
                checkOutput("flush_annul", 64'(div_annul_o), 64'(kind == 1));
                return;
            end
            if (c < k) begin
                checkOutput("run_stall", 64'(stallreq), 64'(1));
                checkOutput("run_we", 64'(hilo_we), 64'(0));
                if (kind == 0 && c == 1) begin
                    checkOutput("mul_a", 64'(mul_a_o), 64'(a));
                    checkOutput("mul_b", 64'(mul_b_o), 64'(b));
                    checkOutput("mul_signed", 64'(mul_signed_o), 64'(o == OP_MULT));
                end
                if (kind == 1) begin
                    if (div_start_o) starts++;
                    if (c == 1) begin
                        checkOutput("div_a", 64'(div_a_o), 64'(a));
                        checkOutput("div_b", 64'(div_b_o), 64'(b));
                        checkOutput("div_signed", 64'(div_signed_o), 64'(o == OP_DIV));
                    end
                end
            end else begin
                checkOutput("done_we", 64'(hilo_we), 64'(ewe));
                checkOutput("done_hi", 64'(hi_o), 64'(ehi));
                checkOutput("done_lo", 64'(lo_o), 64'(elo));
                checkOutput("done_stall", 64'(stallreq), 64'(0));
                if (kind == 1) begin
                    checkOutput("div_start_cycles", 64'(starts), 64'(dlat));
                    checkOutput("div_start_done", 64'(div_start_o), 64'(0));
                end
                if (kind == 2)
                    checkOutput("divzero_no_start", 64'(div_start_o), 64'(0));
            end
        end
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rl;
        int          rf;

        resetn = 1'b0; op_valid = 1'b1; op = OP_MTHI; src_a = 32'h1234_5678;
        src_b = 32'd0; flush = 1'b0; div_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_stall", 64'(stallreq), 64'(0));
        checkOutput("reset_we", 64'(hilo_we), 64'(0));
        checkOutput("reset_hi", 64'(hi_o), 64'(0));
        @(posedge clk); #1;
        resetn = 1'b1; op_valid = 1'b0;

        // Directed cases
        applyStimulus(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1, -1);
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 33, -1);
        applyStimulus(OP_DIV, 32'd5, 32'd0, 1, -1);
        applyStimulus(OP_DIV, 32'd1000, 32'd3, 33, 10);
        applyStimulus(OP_MTLO, 32'd9, 32'd0, 1, -1);

        // Reset in the middle of a multiply
        @(posedge clk); #1;
        op_valid = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'd9; flush = 1'b0; div_ready_i = 1'b0;
        #1;
        checkOutput("pre_reset_stall", 64'(stallreq), 64'(1));
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        checkOutput("mid_reset_stall", 64'(stallreq), 64'(0));
        checkOutput("mid_reset_mul_a", 64'(mul_a_o), 64'(0));
        @(posedge clk); #1;
        resetn = 1'b1; op_valid = 1'b0;
        #1;
        checkOutput("post_reset_busy", 64'(busy), 64'(0));
        checkOutput("post_reset_we", 64'(hilo_we), 64'(0));
        applyStimulus(OP_MULTU, 32'd2, 32'd3, 1, -1);

        // Flush coinciding with divider ready, then an immediate new op
        applyStimulus(OP_DIVU, 32'd50, 32'd6, 5, 6);
        applyStimulus(OP_MULT, 32'h8000_0000, 32'hFFFF_FFFF, 1, -1);
        applyStimulus(3'd6, 32'd1, 32'd1, 1, -1);
        applyStimulus(OP_MTHI, 32'hCAFE_F00D, 32'd0, 1, -1);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) == 1 && rb != 32'd0) rb = 32'($urandom_range(1, 20));
            if (ro == OP_DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            rl = int'($urandom_range(1, 40));
            rf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
            applyStimulus(ro, ra, rb, rl, rf);
        end

        @(posedge clk); #1;
        op_valid = 1'b0; flush = 1'b0; div_ready_i = 1'b0;
        #1;
        checkOutput("final_busy", 64'(busy), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
